// File: rtl/rob_controller.sv
// rob_controller: reorder-buffer sequencing controller.
// Owns the circular head/tail pointers, per-entry valid/ready bits and the
// occupancy count; emits one-hot write enables and clears for the data cells.
// Optional feature macro: ROB_CMPL_BYPASS_EN (same-cycle completion-to-commit
// bypass at the head entry).
//
// Handshakes (strict valid/ready): a transfer fires only in a cycle where both
// valid and ready are high at the rising edge. alloc_ready and commit_valid
// never depend on alloc_valid or commit_ready, so neither side waits on the other.
module rob_controller #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset_async_n,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_tag,
  output logic [DEPTH-1:0] alloc_wen,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_tag,
  output logic [DEPTH-1:0] cmpl_wen,
  output logic             cmpl_err,
  input  logic             commit_ready,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_tag,
  output logic [DEPTH-1:0] commit_clr,
  output logic             flush_clr,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             dbg_state
);

  typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [DEPTH-1:0] ONE_HOT0 = DEPTH'(1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;

  logic run, live, alloc_fire, cmpl_ok, commit_fire;

  // Live cycle: controller running and no flush request this cycle.
  assign run  = (state_q == ST_RUN);
  assign live = run & ~flush;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  assign alloc_ready = live & ~full;
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // The same-tag-as-allocation guard is kept explicit even though the tail
  // entry is never valid while an allocation can fire.
  assign cmpl_ok  = cmpl_valid & live & valid_q[cmpl_tag] & ~ready_q[cmpl_tag]
                  & ~(alloc_fire & (cmpl_tag == tail_q));
  assign cmpl_err = cmpl_valid & live & ~cmpl_ok;

`ifdef ROB_CMPL_BYPASS_EN
  assign commit_valid = live & valid_q[head_q]
                      & (ready_q[head_q] | (cmpl_ok & (cmpl_tag == head_q)));
`else
  assign commit_valid = live & valid_q[head_q] & ready_q[head_q];
`endif
  assign commit_tag  = head_q;
  assign commit_fire = commit_valid & commit_ready;

  assign alloc_wen  = alloc_fire  ? (ONE_HOT0 << tail_q)   : '0;
  assign cmpl_wen   = cmpl_ok     ? (ONE_HOT0 << cmpl_tag) : '0;
  assign commit_clr = commit_fire ? (ONE_HOT0 << head_q)   : '0;
  assign flush_clr  = (state_q == ST_FLUSH);
  assign dbg_state  = state_q;

  // Next state: FLUSH always lasts one cycle; a sampled flush sends RUN to FLUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      default:  state_d = ST_FLUSH;
    endcase
  end

  // Bookkeeping update; commit is applied last so a bypass commit clears ready.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (run && flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cmpl_ok) ready_d[cmpl_tag] = 1'b1;
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end

  // State registers; reset lands in FLUSH so every cell sees one clear cycle.
  always_ff @(posedge clock or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state_q <= ST_FLUSH;
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
// tb_rob_controller: table-driven directed vectors, hand sequences for reset
// and the completion/commit corner, then randomized traffic against a
// queue-level reference model with an in-order commit scoreboard.
module tb_rob_controller;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clock = 1'b0;
  logic             reset_async_n;
  logic             flush, alloc_valid, cmpl_valid, commit_ready;
  logic [IDX_W-1:0] cmpl_tag;
  logic             alloc_ready, cmpl_err, commit_valid, flush_clr, full, empty, dbg_state;
  logic [IDX_W-1:0] alloc_tag, commit_tag;
  logic [DEPTH-1:0] alloc_wen, cmpl_wen, commit_clr;
  logic [IDX_W:0]   count;

  int total = 0;
  int bad   = 0;

  // Clock/reset block.
  always #5 clock = ~clock;

  rob_controller #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_async_n(reset_async_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_wen(alloc_wen), .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .cmpl_wen(cmpl_wen), .cmpl_err(cmpl_err), .commit_ready(commit_ready),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_clr(commit_clr),
    .flush_clr(flush_clr), .count(count), .full(full), .empty(empty),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic fl, av, cv;
    logic [IDX_W-1:0] ct;
    logic cr;
    logic ar;
    logic [IDX_W-1:0] at;
    logic cmv;
    logic [IDX_W-1:0] cmt;
    logic [IDX_W:0] cnt;
    logic err, fcl;
  } vec_t;

  vec_t vecs[$];

  // Reference model: occupancy as head + count, completion flags per tag.
  int  m_head, m_cnt;
  bit  m_rdy[DEPTH];
  bit  m_flushing;
  logic [IDX_W-1:0] exp_q[$];

  function automatic vec_t mk(int fl, int av, int cv, int ct, int cr,
                              int ar, int at, int cmv, int cmt, int cnt, int err, int fcl);
    vec_t v;
    v.fl = fl[0]; v.av = av[0]; v.cv = cv[0]; v.ct = ct[IDX_W-1:0]; v.cr = cr[0];
    v.ar = ar[0]; v.at = at[IDX_W-1:0]; v.cmv = cmv[0]; v.cmt = cmt[IDX_W-1:0];
    v.cnt = cnt[IDX_W:0]; v.err = err[0]; v.fcl = fcl[0];
    return v;
  endfunction

  function automatic logic [DEPTH-1:0] onehot(int i);
    logic [DEPTH-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver task: drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic fl, input logic av, input logic cv,
                       input logic [IDX_W-1:0] ct, input logic cr);
    flush = fl; alloc_valid = av; cmpl_valid = cv; cmpl_tag = ct; commit_ready = cr;
  endtask

  task automatic model_clear();
    m_head = 0; m_cnt = 0; m_flushing = 0;
    for (int i = 0; i < DEPTH; i++) m_rdy[i] = 0;
    exp_q.delete();
  endtask

  initial begin
    logic e_ar, e_cv, e_err, acc, occ, a_fire, c_fire, run;
    int   e_at;
    logic [IDX_W-1:0] popped;

    // Directed table (default build: no completion bypass).
    //           fl av cv ct cr | ar at cmv cmt cnt err fcl
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0,1,0,0,0, 1,i,0,0,i,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,8,0,0)); // 9th alloc refused
    vecs.push_back(mk(0,0,1,3,1, 0,0,0,0,8,0,0)); // complete 3, head not ready
    vecs.push_back(mk(0,0,1,0,1, 0,0,0,0,8,0,0)); // complete 0, no commit yet
    vecs.push_back(mk(0,0,1,1,1, 0,0,1,0,8,0,0)); // commit 0
    vecs.push_back(mk(0,0,0,0,1, 1,0,1,1,7,0,0)); // commit 1
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,2,6,0,0)); // stall on 2
    vecs.push_back(mk(0,0,1,3,0, 1,0,0,2,6,1,0)); // repeated completion
    vecs.push_back(mk(0,0,1,0,0, 1,0,0,2,6,1,0)); // completion to empty slot
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,2,6,0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,2,7,0,0)); // now full
    vecs.push_back(mk(0,0,1,2,0, 0,2,0,2,8,0,0)); // head becomes ready
    vecs.push_back(mk(0,1,0,0,1, 0,2,1,2,8,0,0)); // full: only commit fires
    vecs.push_back(mk(0,1,0,0,1, 1,2,1,3,7,0,0)); // both fire
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,4,7,0,0)); // count held at 7
    vecs.push_back(mk(1,1,1,4,1, 0,3,0,4,7,0,0)); // flush: nothing fires
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,0,0,0,1)); // FLUSH cycle
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0,0)); // alloc_ready two cycles on
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,0,1,0,0));

    // Reset with inputs active: outputs must show the reset state.
    reset_async_n = 1'b0;
    drive(0, 1, 1, 0, 1);
    repeat (2) @(negedge clock);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_alloc_ready", alloc_ready, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_flush_clr", flush_clr, 1);
    check("rst_wens", {alloc_wen, cmpl_wen, commit_clr}, 0);
    check("rst_cmpl_err", cmpl_err, 0);
    drive(0, 0, 0, 0, 0);
    reset_async_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clock); #1;
      drive(vecs[i].fl, vecs[i].av, vecs[i].cv, vecs[i].ct, vecs[i].cr);
      @(negedge clock);
      check($sformatf("v%0d_alloc_ready", i), alloc_ready, vecs[i].ar);
      check($sformatf("v%0d_alloc_tag", i), alloc_tag, vecs[i].at);
      check($sformatf("v%0d_commit_valid", i), commit_valid, vecs[i].cmv);
      check($sformatf("v%0d_commit_tag", i), commit_tag, vecs[i].cmt);
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_full", i), full, vecs[i].cnt == DEPTH);
      check($sformatf("v%0d_empty", i), empty, vecs[i].cnt == 0);
      check($sformatf("v%0d_cmpl_err", i), cmpl_err, vecs[i].err);
      check($sformatf("v%0d_flush_clr", i), flush_clr, vecs[i].fcl);
      check($sformatf("v%0d_alloc_wen", i), alloc_wen,
            (vecs[i].av && vecs[i].ar) ? onehot(vecs[i].at) : '0);
      check($sformatf("v%0d_cmpl_wen", i), cmpl_wen,
            (vecs[i].cv && !vecs[i].fl && !vecs[i].fcl && !vecs[i].err) ? onehot(vecs[i].ct) : '0);
      check($sformatf("v%0d_commit_clr", i), commit_clr,
            (vecs[i].cmv && vecs[i].cr) ? onehot(vecs[i].cmt) : '0);
    end

    // Fresh start for the randomized phase.
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0);
    reset_async_n = 1'b0;
    @(negedge clock);
    reset_async_n = 1'b1;
    model_clear();

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clock); #1;
      flush        = ($urandom_range(0, 29) == 0);
      alloc_valid  = ($urandom_range(0, 2) != 0);
      cmpl_valid   = $urandom_range(0, 1);
      if (m_cnt > 0 && $urandom_range(0, 3) != 0)
        cmpl_tag = IDX_W'((m_head + $urandom_range(0, m_cnt - 1)) % DEPTH);
      else
        cmpl_tag = IDX_W'($urandom_range(0, DEPTH - 1));
      commit_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);

      run   = !m_flushing;
      occ   = ((int'(cmpl_tag) - m_head + DEPTH) % DEPTH) < m_cnt;
      e_ar  = run && !flush && (m_cnt < DEPTH);
      e_at  = (m_head + m_cnt) % DEPTH;
      acc   = run && !flush && cmpl_valid && occ && !m_rdy[cmpl_tag];
      e_err = run && !flush && cmpl_valid && !acc;
      e_cv  = run && !flush && (m_cnt > 0) && m_rdy[m_head];
`ifdef ROB_CMPL_BYPASS_EN
      if (acc && int'(cmpl_tag) == m_head) e_cv = 1'b1;
`endif
      a_fire = alloc_valid && e_ar;
      c_fire = e_cv && commit_ready;

      check("r_dbg_state", dbg_state, run);
      check("r_flush_clr", flush_clr, !run);
      check("r_alloc_ready", alloc_ready, e_ar);
      check("r_count", count, m_cnt);
      check("r_full_empty", {full, empty}, {m_cnt == DEPTH, m_cnt == 0});
      check("r_cmpl_err", cmpl_err, e_err);
      check("r_cmpl_wen", cmpl_wen, acc ? onehot(cmpl_tag) : '0);
      check("r_commit_valid", commit_valid, e_cv);
      check("r_alloc_wen", alloc_wen, a_fire ? onehot(e_at) : '0);
      check("r_commit_clr", commit_clr, c_fire ? onehot(m_head) : '0);
      if (e_ar) check("r_alloc_tag", alloc_tag, e_at);

      // Scoreboard: commits must retire allocated tags in allocation order.
      if (a_fire) exp_q.push_back(IDX_W'(e_at));
      if (c_fire) begin
        if (exp_q.size() == 0) check("r_commit_order_empty", commit_tag, 'hx);
        else begin
          popped = exp_q.pop_front();
          check("r_commit_order", commit_tag, popped);
        end
      end

      // Model update for the coming edge.
      if (m_flushing) m_flushing = 0;
      else if (flush) begin
        model_clear();
        m_flushing = 1;
      end else begin
        if (acc) m_rdy[cmpl_tag] = 1;
        if (a_fire) begin
          m_rdy[e_at] = 0;
          m_cnt++;
        end
        if (c_fire) begin
          m_rdy[m_head] = 0;
          m_head = (m_head + 1) % DEPTH;
          m_cnt--;
        end
      end
    end

    // Mid-operation reset must discard state immediately.
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0);
    reset_async_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_alloc_ready", alloc_ready, 0);
    check("mid_rst_flush_clr", flush_clr, 1);
    check("mid_rst_commit_valid", commit_valid, 0);
    @(negedge clock);
    reset_async_n = 1'b1;

    // Completion at head with the consumer ready.
    @(posedge clock); #1;
    drive(0, 1, 0, 0, 0);
    @(posedge clock); #1;
    drive(0, 0, 1, 0, 1);
    @(negedge clock);
    check("hd_cmpl_wen", cmpl_wen, onehot(0));
`ifdef ROB_CMPL_BYPASS_EN
    check("hd_bypass_commit_valid", commit_valid, 1);
    check("hd_bypass_commit_clr", commit_clr, onehot(0));
`else
    check("hd_commit_valid_wait", commit_valid, 0);
`endif
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
`ifdef ROB_CMPL_BYPASS_EN
    check("hd_bypass_count", count, 0);
    check("hd_bypass_no_recommit", commit_valid, 0);
`else
    check("hd_commit_valid_next", commit_valid, 1);
    check("hd_count", count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
